wb_arbiter: RTL

Write-back arbiter that shares the register file's single write port between the ALU and the load/store unit (LSU). Each requester hands over a (destination index, data) pair through a valid/ready handshake into its own one-entry holding slot. A round-robin, age-aware arbiter drains the slots into a registered write command that drives the register file write port directly. Writes to x0 are discarded at acceptance and never use a write cycle.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_slot.sv | 53 +++++
 rtl/wb_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back arbiter.
package wb_pkg;
    localparam int   WB_XLEN    = 32;
    localparam int   WB_ADDR_W  = 5;
    localparam logic WB_REQ_ALU = 1'b0;
    localparam logic WB_REQ_LSU = 1'b1;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/wb_slot.sv
// One-entry write-back holding slot: handshake, x0 drop, payload and relative age.
module wb_slot
    import wb_pkg::*;
#(
    parameter int   XLEN      = WB_XLEN,
    parameter int   ADDR_W    = WB_ADDR_W,
    parameter logic TIE_OLDER = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [XLEN-1:0]   req_data,
    output logic              ready,
    input  logic              grant,
    input  logic              peer_load,
    input  logic              peer_hold,
    output logic              load,
    output logic              hold,
    output logic              vld_p0,
    output logic [ADDR_W-1:0] rd_p0,
    output logic [XLEN-1:0]   data_p0,
    output logic              older_p0
);
    assign ready = ~rst & (~vld_p0 | grant);
    assign load  = req_valid & ready & (req_rd != '0);
    assign hold  = vld_p0 & ~grant;

    // Stage p0: slot control; older_p0 says this entry predates the peer's entry
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            older_p0 <= 1'b0;
        end else begin
            if (load)
                vld_p0 <= 1'b1;
            else if (grant)
                vld_p0 <= 1'b0;

            if (load)
                older_p0 <= peer_load ? TIE_OLDER : ~peer_hold;
            else if (peer_load && hold)
                older_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            rd_p0   <= req_rd;
            data_p0 <= req_data;
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter between ALU and LSU with round-robin/age priority.
// Optional macro WB_BYPASS_EN adds decode bypass ports driven off the write register.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN   = WB_XLEN,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              rg_write_en,
    output logic [ADDR_W-1:0] rg_des_addr,
    output logic [XLEN-1:0]   rg_des_data,
    output logic              wb_idle
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] byp_addr1,
    input  logic [ADDR_W-1:0] byp_addr2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [XLEN-1:0]   byp_data1,
    output logic [XLEN-1:0]   byp_data2
`endif
);
    logic              alu_load, alu_hold, alu_vld_p0, alu_older_p0;
    logic [ADDR_W-1:0] alu_rd_p0;
    logic [XLEN-1:0]   alu_data_p0;
    logic              lsu_load, lsu_hold, lsu_vld_p0, lsu_older_p0;
    logic [ADDR_W-1:0] lsu_rd_p0;
    logic [XLEN-1:0]   lsu_data_p0;
    logic              gnt_alu, gnt_lsu, both_vld, last_gnt;
    logic              wr_vld_p1;
    logic [ADDR_W-1:0] wr_addr_p1;
    logic [XLEN-1:0]   wr_data_p1;

    wb_slot #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIE_OLDER(1'b0)) u_alu_slot (
        .clk(clk), .rst(rst),
        .req_valid(alu_valid), .req_rd(alu_rd), .req_data(alu_data),
        .ready(alu_ready), .grant(gnt_alu),
        .peer_load(lsu_load), .peer_hold(lsu_hold),
        .load(alu_load), .hold(alu_hold),
        .vld_p0(alu_vld_p0), .rd_p0(alu_rd_p0), .data_p0(alu_data_p0),
        .older_p0(alu_older_p0)
    );

    // Simultaneous acceptance makes the LSU entry the older one
    wb_slot #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIE_OLDER(1'b1)) u_lsu_slot (
        .clk(clk), .rst(rst),
        .req_valid(lsu_valid), .req_rd(lsu_rd), .req_data(lsu_data),
        .ready(lsu_ready), .grant(gnt_lsu),
        .peer_load(alu_load), .peer_hold(alu_hold),
        .load(lsu_load), .hold(lsu_hold),
        .vld_p0(lsu_vld_p0), .rd_p0(lsu_rd_p0), .data_p0(lsu_data_p0),
        .older_p0(lsu_older_p0)
    );

    assign both_vld = alu_vld_p0 & lsu_vld_p0;

    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        if (!rst) begin
            if (both_vld) begin
                if (alu_rd_p0 == lsu_rd_p0)
                    gnt_lsu = lsu_older_p0 | ~alu_older_p0;
                else
                    gnt_lsu = (last_gnt == WB_REQ_ALU);
                gnt_alu = ~gnt_lsu;
            end else begin
                gnt_alu = alu_vld_p0;
                gnt_lsu = lsu_vld_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_gnt <= WB_REQ_LSU;
        else if (both_vld)
            last_gnt <= gnt_lsu ? WB_REQ_LSU : WB_REQ_ALU;
    end

    // Stage p1: registered write command straight into the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= gnt_alu | gnt_lsu;
            if (gnt_lsu) begin
                wr_addr_p1 <= lsu_rd_p0;
                wr_data_p1 <= lsu_data_p0;
            end else if (gnt_alu) begin
                wr_addr_p1 <= alu_rd_p0;
                wr_data_p1 <= alu_data_p0;
            end
        end
    end

    assign rg_write_en = wr_vld_p1;
    assign rg_des_addr = wr_addr_p1;
    assign rg_des_data = wr_data_p1;
    assign wb_idle     = ~alu_vld_p0 & ~lsu_vld_p0 & ~wr_vld_p1;

`ifdef WB_BYPASS_EN
    assign byp_hit1  = wr_vld_p1 & (wr_addr_p1 == byp_addr1) & (byp_addr1 != '0);
    assign byp_hit2  = wr_vld_p1 & (wr_addr_p1 == byp_addr2) & (byp_addr2 != '0);
    assign byp_data1 = wr_data_p1;
    assign byp_data2 = wr_data_p1;
`endif
endmodule
